fifo_wptr_full: RTL and testbench



---
 rtl/fifo_wptr_full.sv | 80 ++++++++
 tb/tb_fifo_wptr_full.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer/flag controller for an async FIFO: binary + Gray write
// pointer, two-flop read-pointer synchroniser, full/almost-full/level/overflow.
module fifo_wptr_full #(
    parameter int ADDR_WIDTH        = 3,
    parameter int ALMOST_FULL_LEVEL = 6
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   rptr_gray,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  woverflow
);
    localparam int          PW  = ADDR_WIDTH + 1;
    localparam logic [31:0] AFL = 32'(ALMOST_FULL_LEVEL);

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] rq1_q, rq2_q;
    logic [PW-1:0] rbin_sync;
    logic [PW-1:0] wlevel_q, wlevel_d;
    logic          wfull_q, wfull_d;
    logic          walmost_full_q, walmost_full_d;
    logic          woverflow_q, woverflow_d;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Gating with wrst keeps the RAM from seeing a write while the block is held in reset.
    assign wen = winc & ~wfull_q & ~wrst;

    always_comb begin
        wbin_d         = wbin_q + {{(PW-1){1'b0}}, wen};
        wgray_d        = wbin_d ^ (wbin_d >> 1);
        rbin_sync      = gray2bin(rq2_q);
        wlevel_d       = wbin_d - rbin_sync;
        // Full when write pointer equals read pointer with the two MSBs inverted (Gray form).
        wfull_d        = (wgray_d == {~rq2_q[ADDR_WIDTH:ADDR_WIDTH-1], rq2_q[ADDR_WIDTH-2:0]});
        walmost_full_d = (32'(wlevel_d) >= AFL);
        woverflow_d    = woverflow_q | (winc & wfull_q);
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin_q         <= '0;
            wgray_q        <= '0;
            rq1_q          <= '0;
            rq2_q          <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            wlevel_q       <= '0;
            woverflow_q    <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wgray_q        <= wgray_d;
            rq1_q          <= rptr_gray;
            rq2_q          <= rq1_q;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            wlevel_q       <= wlevel_d;
            woverflow_q    <= woverflow_d;
        end
    end

    assign waddr        = wbin_q[ADDR_WIDTH-1:0];
    assign wptr_gray    = wgray_q;
    assign wfull        = wfull_q;
    assign walmost_full = walmost_full_q;
    assign wlevel       = wlevel_q;
    assign woverflow    = woverflow_q;
endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full (ADDR_WIDTH=3, ALMOST_FULL_LEVEL=6).
module tb_fifo_wptr_full;
    logic       wclk = 1'b0;
    logic       wrst = 1'b1;
    logic       winc = 1'b0;
    logic [3:0] rptr_gray = 4'b0000;
    logic       wen;
    logic [2:0] waddr;
    logic [3:0] wptr_gray;
    logic       wfull, walmost_full, woverflow;
    logic [3:0] wlevel;

    int n_pass  = 0;
    int n_total = 0;
    logic [3:0] gtab [16];

    fifo_wptr_full #(.ADDR_WIDTH(3), .ALMOST_FULL_LEVEL(6)) dut (
        .wclk(wclk), .wrst(wrst), .winc(winc), .rptr_gray(rptr_gray),
        .wen(wen), .waddr(waddr), .wptr_gray(wptr_gray), .wfull(wfull),
        .walmost_full(walmost_full), .wlevel(wlevel), .woverflow(woverflow)
    );

    always #5 wclk = ~wclk;

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        wrst = 1'b1;
        winc = 1'b0;
        rptr_gray = 4'b0000;
        step();
        wrst = 1'b0;
    endtask

    task automatic test_reset();
        wrst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            winc = i[0];
            #1;
            n_total++;
            if ({wen, waddr, wptr_gray, wfull, walmost_full, wlevel, woverflow} !== 15'b0)
                $display("FAIL reset[%0d]: wen=%b waddr=%0d wptr_gray=%b wfull=%b wafull=%b wlevel=%0d wovf=%b, expected all 0",
                         i, wen, waddr, wptr_gray, wfull, walmost_full, wlevel, woverflow);
            else n_pass++;
            step();
        end
        winc = 1'b0;
        wrst = 1'b0;
    endtask

    task automatic test_fill();
        logic [3:0] gexp [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                 4'b0111, 4'b0101, 4'b0100, 4'b1100};
        rptr_gray = 4'b0000;
        winc = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            #1;
            n_total++;
            if (wen !== 1'b1 || waddr !== 3'(k - 1))
                $display("FAIL fill_addr[%0d]: wen=%b waddr=%0d, expected wen=1 waddr=%0d", k, wen, waddr, k - 1);
            else n_pass++;
            step();
            n_total++;
            if (wptr_gray !== gexp[k-1] || wlevel !== 4'(k) || walmost_full !== (k >= 6) || wfull !== (k == 8))
                $display("FAIL fill[%0d]: wptr_gray=%b wlevel=%0d wafull=%b wfull=%b, expected %b %0d %b %b",
                         k, wptr_gray, wlevel, walmost_full, wfull, gexp[k-1], k, (k >= 6), (k == 8));
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        winc = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n_total++;
            if (wen !== 1'b0)
                $display("FAIL ovf_wen[%0d]: wen=%b, expected 0", i, wen);
            else n_pass++;
            step();
            n_total++;
            if (wptr_gray !== 4'b1100 || woverflow !== 1'b1 || wfull !== 1'b1 || wlevel !== 4'd8)
                $display("FAIL ovf[%0d]: wptr_gray=%b wovf=%b wfull=%b wlevel=%0d, expected 1100 1 1 8",
                         i, wptr_gray, woverflow, wfull, wlevel);
            else n_pass++;
        end
        winc = 1'b0;
        step();
        n_total++;
        if (woverflow !== 1'b1 || wptr_gray !== 4'b1100)
            $display("FAIL ovf_sticky: wovf=%b wptr_gray=%b, expected 1 1100", woverflow, wptr_gray);
        else n_pass++;
    endtask

    task automatic test_release();
        winc = 1'b0;
        rptr_gray = 4'b0001;
        for (int e = 1; e <= 2; e++) begin
            step();
            n_total++;
            if (wfull !== 1'b1 || walmost_full !== 1'b1 || wlevel !== 4'd8)
                $display("FAIL rel_hold[%0d]: wfull=%b wafull=%b wlevel=%0d, expected 1 1 8", e, wfull, walmost_full, wlevel);
            else n_pass++;
        end
        step();
        n_total++;
        if (wfull !== 1'b0 || walmost_full !== 1'b1 || wlevel !== 4'd7)
            $display("FAIL rel_3rd: wfull=%b wafull=%b wlevel=%0d, expected 0 1 7", wfull, walmost_full, wlevel);
        else n_pass++;
        winc = 1'b1;
        #1;
        n_total++;
        if (wen !== 1'b1 || waddr !== 3'd0)
            $display("FAIL rel_write: wen=%b waddr=%0d, expected 1 0", wen, waddr);
        else n_pass++;
        step();
        winc = 1'b0;
        n_total++;
        if (wfull !== 1'b1 || wlevel !== 4'd8 || wptr_gray !== 4'b1101)
            $display("FAIL rel_refull: wfull=%b wlevel=%0d wptr_gray=%b, expected 1 8 1101", wfull, wlevel, wptr_gray);
        else n_pass++;
    endtask

    // Read pointer follows one write behind; with the 3-edge sync path the level settles at 4.
    task automatic test_wrap();
        do_reset();
        winc = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            #1;
            n_total++;
            if (wen !== 1'b1 || waddr !== 3'((k - 1) % 8))
                $display("FAIL wrap_addr[%0d]: wen=%b waddr=%0d, expected 1 %0d", k, wen, waddr, (k - 1) % 8);
            else n_pass++;
            step();
            rptr_gray = gtab[(k - 1) % 16];
            n_total++;
            if (wptr_gray !== gtab[k % 16] || wfull !== 1'b0 || wlevel !== 4'((k < 4) ? k : 4))
                $display("FAIL wrap[%0d]: wptr_gray=%b wfull=%b wlevel=%0d, expected %b 0 %0d",
                         k, wptr_gray, wfull, wlevel, gtab[k % 16], (k < 4) ? k : 4);
            else n_pass++;
        end
        winc = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        winc = 1'b1;
        for (int k = 0; k < 5; k++) step();
        n_total++;
        if (wptr_gray !== 4'b0111 || waddr !== 3'd5)
            $display("FAIL ares_pre: wptr_gray=%b waddr=%0d, expected 0111 5", wptr_gray, waddr);
        else n_pass++;
        #2;
        wrst = 1'b1;
        #1;
        n_total++;
        if ({wen, waddr, wptr_gray, wfull, walmost_full, wlevel, woverflow} !== 15'b0)
            $display("FAIL ares_clear: wen=%b waddr=%0d wptr_gray=%b wfull=%b wafull=%b wlevel=%0d wovf=%b, expected all 0",
                     wen, waddr, wptr_gray, wfull, walmost_full, wlevel, woverflow);
        else n_pass++;
        #1;
        wrst = 1'b0;
        #1;
        n_total++;
        if (wen !== 1'b1 || waddr !== 3'd0)
            $display("FAIL ares_first: wen=%b waddr=%0d, expected 1 0", wen, waddr);
        else n_pass++;
        step();
        winc = 1'b0;
        n_total++;
        if (wptr_gray !== 4'b0001 || wlevel !== 4'd1)
            $display("FAIL ares_after: wptr_gray=%b wlevel=%0d, expected 0001 1", wptr_gray, wlevel);
        else n_pass++;
    endtask

    initial begin
        gtab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
        #1;
        test_reset();
        test_fill();
        test_overflow();
        test_release();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
